// File: rtl/serv_rf_pkg.sv
// Shared definitions for the bit-serial register-file RAM controller.
package serv_rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } rf_ctrl_state_t;

  localparam int GPR_NUM  = 32;
  localparam int CSR_BASE = 32;

  // CSR offsets relative to CSR_BASE
  localparam int MSCRATCH = 0;
  localparam int MTVEC    = 1;
  localparam int MEPC     = 2;
  localparam int MTVAL    = 3;
  localparam int DPC      = 5;

endpackage

// File: rtl/serv_rf_ser2par.sv
// Serial-to-parallel write collector: gathers W serial bits LSB first and
// parks each completed word in a holding register until the RAM slot comes.
module serv_rf_ser2par #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         latch,
  input  logic         din,
  output logic [W-1:0] word
);

  logic [W-1:0] sr;
  logic [W-1:0] sr_next;

  assign sr_next = {din, sr[W-1:1]};

  // Shift new bits in at the MSB; latch the finished word on the last phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      word <= '0;
    end else begin
      if (shift_en) sr <= sr_next;
      if (latch) word <= sr_next;
    end
  end

endmodule

// File: rtl/serv_rf_ram_ctrl.sv
// Register-file RAM controller: converts two serial read ports and two serial
// write ports to/from a single-port W-bit RAM, one RAM access per cycle.
module serv_rf_ram_ctrl
  import serv_rf_pkg::*;
#(
  parameter  int W        = 8,
  parameter  int CSR_REGS = 8,
  localparam int WPR      = 32 / W,
  localparam int RW       = $clog2(32 + CSR_REGS),
  localparam int AW       = RW + $clog2(WPR)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rreq,
  input  logic [RW-1:0] i_rreg0,
  input  logic [RW-1:0] i_rreg1,
  output logic          o_ready,
  output logic          o_rdata0,
  output logic          o_rdata1,
  input  logic [RW-1:0] i_wreg0,
  input  logic [RW-1:0] i_wreg1,
  input  logic          i_wen0,
  input  logic          i_wen1,
  input  logic          i_wdata0,
  input  logic          i_wdata1,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_wen,
  output logic          o_ram_ren,
  output logic [W-1:0]  o_ram_wdata,
  input  logic [W-1:0]  i_ram_rdata
);

  localparam int WB = $clog2(WPR);
  localparam int PB = $clog2(W);

  rf_ctrl_state_t state;
  logic [1:0]     sub;
  logic [4:0]     cnt;
  logic [RW-1:0]  rreg0, rreg1, wreg0, wreg1;
  logic           wen0, wen1;
  logic [W-1:0]   rsh0, rsh1, rbuf0, rbuf1;
  logic           pend0, pend1;
  logic           rd0_slot, rd1_slot;
  logic [W-1:0]   hold0, hold1;
  logic [4:0]     phase, win;
  logic           last_win, phase_end, streaming, wen0_eff;

  assign phase     = cnt & 5'(W - 1);
  assign win       = cnt >> PB;
  assign last_win  = (win == 5'(WPR - 1));
  assign phase_end = (phase == 5'(W - 1));
  assign streaming = (state == ST_STREAM);
  // x0 is hard-wired to zero, so port 0 never commits to it
  assign wen0_eff  = wen0 && (wreg0 != '0);

  assign o_ready  = (state == ST_PRE) && (sub == 2'd2);
  assign o_rdata0 = rsh0[0];
  assign o_rdata1 = rsh1[0];

  function automatic logic [AW-1:0] ram_addr(input logic [RW-1:0] r, input logic [4:0] w);
    return (AW'(r) << WB) | AW'(w);
  endfunction

  // Slot arbiter: at most one RAM access per cycle, reads and writes exclusive
  always_comb begin
    o_ram_ren   = 1'b0;
    o_ram_wen   = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    rd0_slot    = 1'b0;
    rd1_slot    = 1'b0;
    case (state)
      ST_PRE: begin
        if (sub == 2'd0) begin
          o_ram_ren  = 1'b1;
          o_ram_addr = ram_addr(rreg0, 5'd0);
          rd0_slot   = 1'b1;
        end else if (sub == 2'd1) begin
          o_ram_ren  = 1'b1;
          o_ram_addr = ram_addr(rreg1, 5'd0);
          rd1_slot   = 1'b1;
        end
      end
      ST_STREAM: begin
        if (phase == 5'd0 && !last_win) begin
          o_ram_ren  = 1'b1;
          o_ram_addr = ram_addr(rreg0, win + 5'd1);
          rd0_slot   = 1'b1;
        end else if (phase == 5'd1 && !last_win) begin
          o_ram_ren  = 1'b1;
          o_ram_addr = ram_addr(rreg1, win + 5'd1);
          rd1_slot   = 1'b1;
        end else if (phase == 5'd2 && win != 5'd0 && wen0_eff) begin
          o_ram_wen   = 1'b1;
          o_ram_addr  = ram_addr(wreg0, win - 5'd1);
          o_ram_wdata = hold0;
        end else if (phase == 5'd3 && win != 5'd0 && wen1) begin
          o_ram_wen   = 1'b1;
          o_ram_addr  = ram_addr(wreg1, win - 5'd1);
          o_ram_wdata = hold1;
        end
      end
      ST_FLUSH: begin
        if (sub == 2'd2 && wen0_eff) begin
          o_ram_wen   = 1'b1;
          o_ram_addr  = ram_addr(wreg0, 5'(WPR - 1));
          o_ram_wdata = hold0;
        end else if (sub == 2'd3 && wen1) begin
          o_ram_wen   = 1'b1;
          o_ram_addr  = ram_addr(wreg1, 5'(WPR - 1));
          o_ram_wdata = hold1;
        end
      end
      default: ;
    endcase
  end

  // Transaction sequencer; register indices and enables frozen at request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      sub   <= 2'd0;
      cnt   <= 5'd0;
      rreg0 <= '0;
      rreg1 <= '0;
      wreg0 <= '0;
      wreg1 <= '0;
      wen0  <= 1'b0;
      wen1  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_rreq) begin
            state <= ST_PRE;
            sub   <= 2'd0;
            rreg0 <= i_rreg0;
            rreg1 <= i_rreg1;
            wreg0 <= i_wreg0;
            wreg1 <= i_wreg1;
            wen0  <= i_wen0;
            wen1  <= i_wen1;
          end
        end
        ST_PRE: begin
          if (sub == 2'd2) begin
            state <= ST_STREAM;
            sub   <= 2'd0;
            cnt   <= 5'd0;
          end else begin
            sub <= sub + 2'd1;
          end
        end
        ST_STREAM: begin
          if (cnt == 5'd31) begin
            state <= ST_FLUSH;
            cnt   <= 5'd0;
            sub   <= 2'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          if (sub == 2'd3) begin
            state <= ST_IDLE;
            sub   <= 2'd0;
          end else begin
            sub <= sub + 2'd1;
          end
        end
      endcase
    end
  end

  // Read path: capture RAM data one cycle after each read slot, then feed
  // the shift registers at the end of each window (nothing after the last)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      rbuf0 <= '0;
      rbuf1 <= '0;
      rsh0  <= '0;
      rsh1  <= '0;
    end else begin
      pend0 <= rd0_slot;
      pend1 <= rd1_slot;
      if (pend0) rbuf0 <= i_ram_rdata;
      if (pend1) rbuf1 <= i_ram_rdata;
      if (o_ready) begin
        rsh0 <= rbuf0;
        rsh1 <= i_ram_rdata;
      end else if (streaming) begin
        if (phase_end && !last_win) begin
          rsh0 <= rbuf0;
          rsh1 <= rbuf1;
        end else begin
          rsh0 <= {1'b0, rsh0[W-1:1]};
          rsh1 <= {1'b0, rsh1[W-1:1]};
        end
      end
    end
  end

  serv_rf_ser2par #(.W(W)) u_wr0 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_en (streaming),
    .latch    (streaming && phase_end),
    .din      (i_wdata0),
    .word     (hold0)
  );

  serv_rf_ser2par #(.W(W)) u_wr1 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_en (streaming),
    .latch    (streaming && phase_end),
    .din      (i_wdata1),
    .word     (hold1)
  );

endmodule
